stats_readout_seq: RTL and testbench
====================================

# stats_readout_seq

Bus-master sequencer on the control-system (cs) port of the peripheral system. On a start pulse it reads the cycle-count statistics: for each index it writes the word index to `STATS_BASE`, then reads `STATS_BASE` back. Each captured 32-bit word goes out on a valid/ready stream to the host-side transmitter (UART/JTAG TX). It shares the cs bus with the host command path through a request/grant pair.

## Interface
Parameters:
- N_WORDS, 6, number of stats words read; indices 0..N_WORDS-1; legal range 1..8.

Ports:
- clock_i  in  1  system clock
- resetn_i  in  1  reset; asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the sequence completes
- bus_req_o  out  1  cs bus request
- bus_gnt_i  in  1  cs bus grant from the external mux
- req_cs_o  out  1  cs request strobe to the peripheral system
- rw_cs_o  out  1  1 = write, 0 = read
- add_cs_o  out  `BW_BYTE_ADDR+1  cs address; always `STATS_BASE when req_cs_o is high, else 0
- data_cs_o  out  32  write data: {29'b0, idx[2:0]}
- data_cs_i  in  32  read data from the peripheral system; valid one cycle after the read strobe
- word_o  out  32  stream data
- word_valid_o  out  1  stream valid
- word_ready_i  in  1  stream ready

## Operation
- States: IDLE, WAIT_GNT, WR_SEL, RD_REQ, RD_CAP, OUT, CSUM, DONE.
- IDLE: if start_i, clear idx and the checksum, then go to WAIT_GNT. start_i in any other state is ignored.
- WAIT_GNT: bus_req_o=1. If bus_gnt_i, go to WR_SEL.
- WR_SEL: if bus_gnt_i, drive req_cs_o=1, rw_cs_o=1, add_cs_o=`STATS_BASE, data_cs_o=idx, and go to RD_REQ. If bus_gnt_i is low, issue no strobe and go to WAIT_GNT.
- RD_REQ: if bus_gnt_i, drive req_cs_o=1, rw_cs_o=0, add_cs_o=`STATS_BASE, and go to RD_CAP. If bus_gnt_i is low, issue no strobe and go to WAIT_GNT; the current idx is restarted from WR_SEL.
- RD_CAP: register data_cs_i into word_o, XOR it into the checksum, go to OUT. Grant is ignored in this state.
- OUT: word_valid_o=1; word_o is held stable until the handshake.
  - On word_ready_i with idx<N_WORDS-1: idx+1, then WR_SEL if bus_gnt_i else WAIT_GNT.
  - On word_ready_i with idx=N_WORDS-1: go to CSUM if the checksum feature is compiled in, else DONE.
- CSUM: word_o=checksum, word_valid_o=1. On word_ready_i, go to DONE.
- DONE: done_o=1 for one cycle, bus_req_o drops, go to IDLE.
- bus_req_o is high from WAIT_GNT through CSUM inclusive.
- The cs strobes (req_cs_o, rw_cs_o, add_cs_o, data_cs_o) are registered outputs and are 0 outside WR_SEL/RD_REQ.
- idx is 3 bits. No wrap occurs because N_WORDS<=8.
- A 32'hDEADBEAF read (peripheral held in reset) is forwarded unchanged; the block does not filter it.

## Timing
- Reset: asynchronous, and it aborts any sequence immediately. State=IDLE, idx=0, checksum=0. All outputs 0: busy_o, done_o, bus_req_o, req_cs_o, rw_cs_o, add_cs_o, data_cs_o, word_o, word_valid_o.
- start_i sampled at edge k: WAIT_GNT in cycle k+1. With bus_gnt_i already high: WR_SEL at k+2, RD_REQ at k+3, RD_CAP at k+4, first word_valid_o at k+5.
- Each further word takes 4 cycles (WR_SEL, RD_REQ, RD_CAP, OUT) when word_ready_i and bus_gnt_i are continuously high.
- Write-then-read ordering: the peripheral latches the selected count at the WR_SEL edge. The RD_REQ read therefore returns that count, which the block captures at the RD_CAP edge.
- Backpressure: word_valid_o stays high and word_o stays stable while word_ready_i is low. The handshake completes on the edge where valid and ready are both high.
- Grant loss: dropping bus_gnt_i during WR_SEL or RD_REQ costs one cycle to WAIT_GNT plus a full restart of the current word. No partial word is emitted.

## Configuration
- STATS_CHECKSUM_EN:
  - Defined: after the last word, one extra stream word is sent equal to the XOR of all N_WORDS words (seed 0). Total stream length is N_WORDS+1, and the CSUM state exists.
  - Undefined: the CSUM state and the checksum register are removed. The stream is exactly N_WORDS words, and OUT goes straight to DONE.

## Test plan
- Nominal, counts = 32'h11,22,33,44,55,66; gnt=1, ready=1, macro on. Pulse start:
  - stream is 11,22,33,44,55,66 then 32'h00000077;
  - first valid 5 cycles after the start edge;
  - done_o 27 cycles after the start edge.
- cs bus check: data_cs_o on successive write strobes is 0..5. Each write is immediately followed by a read, all at `STATS_BASE. No strobe appears outside WR_SEL/RD_REQ.
- Backpressure: hold ready low 10 cycles on word 2 (32'h33). word_o must stay 32'h33 with valid high throughout, and no cs strobes are issued during the stall.
- Grant drop: deassert gnt during RD_REQ of idx 3 for 4 cycles. No read strobe issues while gnt is low; the write for idx 3 is reissued afterwards, and the stream stays 11..66 with no duplicates.
- Reset and start interaction:
  - asserting resetn_i low during idx 4 immediately clears every output to 0;
  - after release, a new start produces the full sequence from idx 0;
  - start_i pulsed while busy has no effect.
- Macro off: same stimulus as the nominal case gives exactly 6 words; done_o is one cycle after the 6th handshake.

Source files
------------

// File: rtl/stats_readout_seq.sv
// Purpose : cs-bus master that reads N_WORDS cycle-count stats (write index, read back) and streams each word to the host TX.
// Latency : first word valid 5 cycles after the start edge with grant held; each further word 4 cycles with grant and ready high.
// Backpress: word_valid_o/word_o hold while word_ready_i is low; no cs strobes are issued during the stall.
//
// Ports:
//   clock_i, resetn_i          clock, async active-low reset
//   start_i                    start pulse (only honoured in IDLE)
//   busy_o, done_o             busy in any non-IDLE state, one-cycle completion pulse
//   bus_req_o, bus_gnt_i       cs bus request/grant with the host command path
//   req_cs_o, rw_cs_o,
//   add_cs_o, data_cs_o        cs strobe, 1=write, address, write data
//   data_cs_i                  cs read data, valid the cycle after a read strobe
//   word_o, word_valid_o,
//   word_ready_i               output stream to the host transmitter
//
// Optional feature: define STATS_CHECKSUM_EN to append an XOR checksum word after the last stats word.

`ifndef BW_BYTE_ADDR
`define BW_BYTE_ADDR 15
`endif
`ifndef STATS_BASE
`define STATS_BASE 16'h0040
`endif

module stats_readout_seq #(
    parameter int N_WORDS = 6
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    bus_req_o,
    input  logic                    bus_gnt_i,
    output logic                    req_cs_o,
    output logic                    rw_cs_o,
    output logic [`BW_BYTE_ADDR:0]  add_cs_o,
    output logic [31:0]             data_cs_o,
    input  logic [31:0]             data_cs_i,
    output logic [31:0]             word_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i
);

    localparam logic [`BW_BYTE_ADDR:0] STATS_ADDR = `STATS_BASE;
    localparam logic [2:0]             LAST_IDX   = 3'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_GNT = 3'd1,
        S_WR_SEL   = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_CAP   = 3'd4,
        S_OUT      = 3'd5,
`ifdef STATS_CHECKSUM_EN
        S_CSUM     = 3'd6,
`endif
        S_DONE     = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [31:0] r_word;
    logic        r_cs_req;
    logic        r_cs_rw;
    logic [2:0]  r_cs_idx;
    logic        w_cs_en;
`ifdef STATS_CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and index logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (bus_gnt_i) w_state_nxt = S_WR_SEL;
            end
            // Losing grant before the read strobe restarts the current
            // index from the select write, so no partial word escapes.
            S_WR_SEL:   w_state_nxt = bus_gnt_i ? S_RD_REQ : S_WAIT_GNT;
            S_RD_REQ:   w_state_nxt = bus_gnt_i ? S_RD_CAP : S_WAIT_GNT;
            S_RD_CAP:   w_state_nxt = S_OUT;
            S_OUT: begin
                if (word_ready_i) begin
                    if (r_idx == LAST_IDX) begin
`ifdef STATS_CHECKSUM_EN
                        w_state_nxt = S_CSUM;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = bus_gnt_i ? S_WR_SEL : S_WAIT_GNT;
                    end
                end
            end
`ifdef STATS_CHECKSUM_EN
            S_CSUM: begin
                if (word_ready_i) w_state_nxt = S_DONE;
            end
`endif
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index, captured word, checksum, cs command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_idx    <= 3'd0;
            r_word   <= 32'd0;
            r_cs_req <= 1'b0;
            r_cs_rw  <= 1'b0;
            r_cs_idx <= 3'd0;
`ifdef STATS_CHECKSUM_EN
            r_csum   <= 32'd0;
`endif
        end else begin
            r_idx <= w_idx_nxt;
            if (r_state == S_RD_CAP) begin
                r_word <= data_cs_i;
            end
`ifdef STATS_CHECKSUM_EN
            if (r_state == S_IDLE && start_i) begin
                r_csum <= 32'd0;
            end else if (r_state == S_RD_CAP) begin
                r_csum <= r_csum ^ data_cs_i;
            end
`endif
            // The cs command is prepared on entry to WR_SEL/RD_REQ so it
            // comes straight out of flops during those states.
            r_cs_req <= (w_state_nxt == S_WR_SEL) || (w_state_nxt == S_RD_REQ);
            r_cs_rw  <= (w_state_nxt == S_WR_SEL);
            r_cs_idx <= (w_state_nxt == S_WR_SEL) ? w_idx_nxt : 3'd0;
        end
    end

    // A cycle in which grant has been withdrawn must not touch the bus,
    // even though the command flops were already loaded.
    assign w_cs_en   = r_cs_req & bus_gnt_i;

    assign req_cs_o  = w_cs_en;
    assign rw_cs_o   = w_cs_en & r_cs_rw;
    assign add_cs_o  = w_cs_en ? STATS_ADDR : '0;
    assign data_cs_o = w_cs_en ? {29'd0, r_cs_idx} : 32'd0;

    // ------------------------------------------------------------------
    // State-decoded status and stream outputs
    // ------------------------------------------------------------------
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign bus_req_o = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef STATS_CHECKSUM_EN
    assign word_valid_o = (r_state == S_OUT) || (r_state == S_CSUM);
    assign word_o       = (r_state == S_CSUM) ? r_csum : r_word;
`else
    assign word_valid_o = (r_state == S_OUT);
    assign word_o       = r_word;
`endif

endmodule

// File: tb/tb_stats_readout_seq.sv
// Purpose : directed self-checking bench for stats_readout_seq with a small peripheral model on the cs bus.
// Latency : checks first-valid and done timing relative to the start edge.
// Backpress: exercises stream stall, grant loss and mid-sequence reset.

`ifndef BW_BYTE_ADDR
`define BW_BYTE_ADDR 15
`endif
`ifndef STATS_BASE
`define STATS_BASE 16'h0040
`endif

module tb_stats_readout_seq;

    localparam logic [`BW_BYTE_ADDR:0] STATS_ADDR = `STATS_BASE;
`ifdef STATS_CHECKSUM_EN
    localparam int DONE_LAT = 27;
`else
    localparam int DONE_LAT = 26;
`endif

    logic                   clock_i      = 1'b0;
    logic                   resetn_i     = 1'b0;
    logic                   start_i      = 1'b0;
    logic                   bus_gnt_i    = 1'b1;
    logic                   word_ready_i = 1'b1;
    logic                   busy_o, done_o, bus_req_o;
    logic                   req_cs_o, rw_cs_o;
    logic [`BW_BYTE_ADDR:0] add_cs_o;
    logic [31:0]            data_cs_o, data_cs_i, word_o;
    logic                   word_valid_o;

    stats_readout_seq #(.N_WORDS(6)) dut (
        .clock_i      (clock_i),
        .resetn_i     (resetn_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .req_cs_o     (req_cs_o),
        .rw_cs_o      (rw_cs_o),
        .add_cs_o     (add_cs_o),
        .data_cs_o    (data_cs_o),
        .data_cs_i    (data_cs_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // Peripheral model: write latches the selected index, read returns that
    // count one cycle later; otherwise the read bus shows the reset pattern.
    logic [31:0] counts [8];
    logic [2:0]  p_sel = 3'd0;
    logic [31:0] p_rd  = 32'hDEADBEAF;
    always @(posedge clock_i) begin
        if (req_cs_o && rw_cs_o) p_sel <= data_cs_o[2:0];
        p_rd <= (req_cs_o && !rw_cs_o) ? counts[p_sel] : 32'hDEADBEAF;
    end
    assign data_cs_i = p_rd;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: stream handshakes, cs strobe log, protocol violations, timing.
    logic [31:0] stream [$];
    logic [3:0]  cs_log [$];
    int          viol     = 0;
    int          first_vld = -1;
    int          done_cyc = -1;
    int          s_cyc    = 0;

    always @(negedge clock_i) begin
        if (resetn_i) begin
            if (word_valid_o && word_ready_i) stream.push_back(word_o);
            if (word_valid_o && first_vld < 0) first_vld = cyc;
            if (done_o) done_cyc = cyc;
            if (req_cs_o) begin
                cs_log.push_back({rw_cs_o, data_cs_o[2:0]});
                if (add_cs_o !== STATS_ADDR) viol++;
                if (data_cs_o[31:3] !== 29'd0) viol++;
                if (!bus_gnt_i) viol++;
                if (word_valid_o) viol++;
                if (!bus_req_o) viol++;
            end else if (add_cs_o !== '0 || rw_cs_o || data_cs_o !== 32'd0) begin
                viol++;
            end
        end
    end

    logic [31:0] exp_words [$];
    logic [3:0]  exp_log [$];

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic build_exp(input bit gdrop);
        logic [31:0] x;
        x = 32'd0;
        exp_words.delete();
        exp_log.delete();
        for (int i = 0; i < 6; i++) begin
            exp_words.push_back(counts[i]);
            x = x ^ counts[i];
            if (gdrop && i == 3) exp_log.push_back(4'(8 + i));
            exp_log.push_back(4'(8 + i));
            exp_log.push_back(4'h0);
        end
`ifdef STATS_CHECKSUM_EN
        exp_words.push_back(x);
`endif
    endtask

    task automatic start_run();
        stream.delete();
        cs_log.delete();
        viol      = 0;
        first_vld = -1;
        done_cyc  = -1;
        start_i   = 1'b1;
        s_cyc     = cyc;
        step();
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && done_cyc < 0; i++) step();
        chk($sformatf("%s done_seen", tag), 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_run(input string tag, input int exp_done);
        int lb;
        chk($sformatf("%s nwords", tag), 32'(stream.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size(); i++) begin
            chk($sformatf("%s word%0d", tag, i),
                (i < stream.size()) ? stream[i] : 32'hFFFF_FFFF, exp_words[i]);
        end
        lb = 0;
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i >= cs_log.size() || cs_log[i] !== exp_log[i]) lb++;
        end
        chk($sformatf("%s cs_log_len", tag), 32'(cs_log.size()), 32'(exp_log.size()));
        chk($sformatf("%s cs_log_bad", tag), 32'(lb), 32'd0);
        chk($sformatf("%s cs_viol", tag), 32'(viol), 32'd0);
        chk($sformatf("%s first_vld_lat", tag), 32'(first_vld - s_cyc), 32'd5);
        chk($sformatf("%s done_lat", tag), 32'(done_cyc - s_cyc), 32'(exp_done));
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s busy", tag), 32'(busy_o), 32'd0);
        chk($sformatf("%s done", tag), 32'(done_o), 32'd0);
        chk($sformatf("%s bus_req", tag), 32'(bus_req_o), 32'd0);
        chk($sformatf("%s req_cs", tag), 32'(req_cs_o), 32'd0);
        chk($sformatf("%s rw_cs", tag), 32'(rw_cs_o), 32'd0);
        chk($sformatf("%s add_cs", tag), 32'(add_cs_o), 32'd0);
        chk($sformatf("%s data_cs", tag), data_cs_o, 32'd0);
        chk($sformatf("%s word", tag), word_o, 32'd0);
        chk($sformatf("%s word_valid", tag), 32'(word_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_bad;
        counts[0] = 32'h11; counts[1] = 32'h22; counts[2] = 32'h33; counts[3] = 32'h44;
        counts[4] = 32'h55; counts[5] = 32'h66; counts[6] = 32'h0;  counts[7] = 32'h0;

        // Reset state
        resetn_i = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        resetn_i = 1'b1;
        step();

        // Nominal run, grant and ready held high
        build_exp(1'b0);
        start_run();
        wait_done("nom");
        check_run("nom", DONE_LAT);
        chk("nom idle_after", 32'(busy_o), 32'd0);

        // Backpressure: ready low for 10 extra cycles while word 2 is shown
        build_exp(1'b0);
        start_run();
        for (int i = 0; i < 100 && !(word_valid_o && word_o == 32'h22); i++) step();
        step();
        word_ready_i = 1'b0;
        for (int i = 0; i < 100 && !word_valid_o; i++) step();
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!word_valid_o || word_o !== 32'h33) stall_bad++;
            step();
        end
        word_ready_i = 1'b1;
        wait_done("bp");
        check_run("bp", DONE_LAT + 10);
        chk("bp stall_stable", 32'(stall_bad), 32'd0);

        // Grant withdrawn during the read request of idx 3 for 4 cycles
        build_exp(1'b1);
        start_run();
        for (int i = 0; i < 100 && !(req_cs_o && rw_cs_o && data_cs_o == 32'd3); i++) step();
        step();
        bus_gnt_i = 1'b0;
        repeat (4) step();
        bus_gnt_i = 1'b1;
        wait_done("gnt");
        check_run("gnt", DONE_LAT + 6);

        // Reset asserted during idx 4 aborts at once
        build_exp(1'b0);
        start_run();
        for (int i = 0; i < 100 && !(req_cs_o && rw_cs_o && data_cs_o == 32'd4); i++) step();
        resetn_i = 1'b0;
        #1;
        chk_idle("abort");
        step();
        step();
        resetn_i = 1'b1;
        step();

        // Fresh run after reset, with a stray start pulse while busy
        start_run();
        for (int i = 0; i < 100 && !word_valid_o; i++) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done("rst");
        check_run("rst", DONE_LAT);
        repeat (5) step();
        chk("rst idle_after", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
